// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap control FSM and 100 Hz tick prescaler for the stopwatch digit chain.
// Define STOPWATCH_CTRL_OVF_STOP_EN to add max_reached/ovf overflow stop.
module stopwatch_ctrl #(
  parameter int DIV   = 500000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
`ifdef STOPWATCH_CTRL_OVF_STOP_EN
  input  logic       max_reached,
  output logic       ovf,
`endif
  output logic       cnt_en,
  output logic       clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_TOP = CNT_W'(DIV - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_presc;
  logic             r_cnt_en;
  logic             r_ovf;
  logic [1:0]       r_ss_sync;
  logic [1:0]       r_lr_sync;
  logic             r_ss_prev;
  logic             r_lr_prev;

  logic w_ev_ss;
  logic w_ev_lr;
  logic w_tick;
  logic w_stop;
  logic w_ss_resume;

  assign w_ev_ss     = r_ss_sync[1] & ~r_ss_prev;
  assign w_ev_lr     = r_lr_sync[1] & ~r_lr_prev;
  assign w_tick      = (r_presc == LP_TOP);
  // Once overflow has stopped the chain, only lap/reset may leave PAUSE.
  assign w_ss_resume = w_ev_ss & ~r_ovf;

`ifdef STOPWATCH_CTRL_OVF_STOP_EN
  assign w_stop = w_tick & max_reached;
  assign ovf    = r_ovf;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; reset is synchronous and overrides everything.
    if (rst) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_cnt_en  <= 1'b0;
      r_ovf     <= 1'b0;
      r_ss_sync <= '0;
      r_lr_sync <= '0;
      r_ss_prev <= 1'b0;
      r_lr_prev <= 1'b0;
    end else begin
      r_ss_sync <= {r_ss_sync[0], btn_ss};
      r_lr_sync <= {r_lr_sync[0], btn_lr};
      r_ss_prev <= r_ss_sync[1];
      r_lr_prev <= r_lr_sync[1];
      r_cnt_en  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          r_ovf   <= 1'b0;
          if (w_ev_ss) r_state <= S_RUN;
        end
        S_PAUSE: begin
          if (w_ss_resume) begin
            r_state <= S_RUN;
          end else if (w_ev_lr) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: begin
          // Leaving on a due tick swallows it and parks the prescaler at the top,
          // so the tick fires on the first cycle after resuming.
          if (w_stop || w_ev_ss) begin
            r_state <= S_PAUSE;
            r_ovf   <= r_ovf | w_stop;
            if (!w_tick) r_presc <= r_presc + CNT_W'(1);
          end else begin
            if (w_ev_lr) r_state <= (r_state == S_RUN) ? S_LAP : S_RUN;
            if (w_tick) begin
              r_presc  <= '0;
              r_cnt_en <= 1'b1;
            end else begin
              r_presc <= r_presc + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign cnt_en    = r_cnt_en;
  assign state     = r_state;
  assign clr       = (r_state == S_IDLE);
  assign disp_hold = (r_state == S_LAP);
  assign running   = (r_state == S_RUN) || (r_state == S_LAP);

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM for the stopwatch digit-counter chain: centesimas → decimas → seconds → minutes.
- Converts two raw push-buttons, start/stop and lap/reset, into sequencing signals for the counters and the display:
  - a 100 Hz count enable that drives the centesimas stage,
  - a counter clear,
  - a display-freeze (lap) signal.
- Sits between the button inputs and the counter chain; owns all start/stop/lap/clear decisions.

Parameters:
- DIV, 500000, clk cycles per count tick (50 MHz → 100 Hz); legal range 2..2^CNT_W.
- CNT_W, 20, prescaler counter width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_ss  input  1  raw start/stop button, asynchronous, active-high
- btn_lr  input  1  raw lap/reset button, asynchronous, active-high
- cnt_en  output  1  one-cycle pulse per tick; advances the centesimas counter
- clr  output  1  clear to all digit counters; level, high in IDLE
- disp_hold  output  1  display freeze, high in LAP
- running  output  1  high in RUN or LAP
- state  output  2  IDLE=0, RUN=1, PAUSE=2, LAP=3

Behaviour:
- Reset is synchronous, active-high, with priority over everything. After reset:
  - state=IDLE, prescaler=0, all synchronizer/edge flops=0,
  - cnt_en=0, clr=1, disp_hold=0, running=0.
- Reset asserted mid-operation → IDLE on the next clk edge; any count in progress is lost.
- Button input path, per button:
  - 2-flop synchronizer, then a previous-value flop; a press is the rising edge of the synchronized signal.
  - Edge is seen 2 clk after the first sampling edge at which the input is high; the state register updates on the 3rd edge.
  - A held button produces exactly one event.
  - A button held through reset release produces one event after reset.
- Simultaneous ss and lr events in the same cycle: ss wins, lr is discarded.
- FSM transitions (ev_ss / ev_lr = edge pulses):
  - IDLE: ev_ss → RUN; ev_lr ignored.
  - RUN: ev_ss → PAUSE; ev_lr → LAP.
  - LAP: ev_ss → PAUSE (freeze released); ev_lr → RUN (display resumes live).
  - PAUSE: ev_ss → RUN; ev_lr → IDLE.
- Outputs are registered or decoded from the registered state only; none are combinational from inputs.
  - clr = (state==IDLE).
  - disp_hold = (state==LAP).
  - running = RUN|LAP.
- Prescaler:
  - Counts 0..DIV-1 only while running; wraps to 0.
  - Holds its value in PAUSE, so resume keeps the fractional tick.
  - Forced to 0 in IDLE.
- cnt_en:
  - High for exactly 1 cycle when prescaler==DIV-1 while running.
  - First pulse arrives DIV cycles after entry to RUN from IDLE.
  - Never asserted in IDLE or PAUSE.
- Leaving RUN/LAP on the same cycle the prescaler hits DIV-1: the transition wins, cnt_en stays 0, and the prescaler holds DIV-1.
  - On resume, the next tick fires 1 cycle after re-entering RUN.
- Continuous counting: counting never stops on its own (see Optional Feature).

Optional Feature:
- Macro: STOPWATCH_CTRL_OVF_STOP_EN.
- Defined:
  - Adds input max_reached (1 bit, high when the digit chain shows its maximum value) and output ovf (1 bit).
  - In RUN or LAP, when a tick is due and max_reached=1: cnt_en is suppressed, state → PAUSE, and ovf is set.
  - ovf is sticky; cleared only by IDLE or rst.
  - While ovf=1, ev_ss in PAUSE is ignored; ev_lr still → IDLE.
- Undefined:
  - Ports absent; counters wrap freely.

Test Plan:
- Reset, no buttons, 50 cycles → state=0, clr=1, cnt_en never 1, running=0.
- DIV=4: press ss (held 10 cycles) → state=1 on 3rd edge; cnt_en pulses every 4 cycles, first pulse 4 cycles after entry; one event only despite hold.
- DIV=4, RUN: press ss 2 cycles after a tick → PAUSE, prescaler holds 2; press ss again → first tick after 1 running cycle, then every 4.
- RUN: press lr → state=3, disp_hold=1, cnt_en continues; press lr → state=1, disp_hold=0; ss then lr from PAUSE → IDLE, clr=1, prescaler=0.
- Press ss and lr on the same cycle from RUN → state=2 (PAUSE), not LAP; assert rst while in LAP → next cycle state=0, clr=1, disp_hold=0.
- With STOPWATCH_CTRL_OVF_STOP_EN, DIV=4, max_reached=1 in RUN → no cnt_en, state=2, ovf=1; ss ignored; lr → state=0, ovf=0.
